// File: rtl/smol_alu_arb_pkg.sv
// Shared types for the smolALU arbiter: ALU widths, op codes, flag bundle,
// response-slot state and the debug view of the arbiter state.
package smol_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 5;

   typedef enum logic [OP_W-1:0] {
      ALU_ADD  = 5'd0,
      ALU_SUB  = 5'd1,
      ALU_AND  = 5'd2,
      ALU_OR   = 5'd3,
      ALU_XOR  = 5'd4,
      ALU_SRL  = 5'd5,
      ALU_SLL  = 5'd6,
      ALU_SLTU = 5'd7
   } alu_op_e;

   typedef struct packed {
      logic overflow;
      logic carry;
   } alu_flags_t;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   // Fixed 2-bit fields cover the full 2..4 requester range.
   typedef struct packed {
      slot_state_e state;
      logic [1:0]  owner;
      logic [1:0]  rr_ptr;
   } arb_dbg_t;

   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/smol_alu_arb_if.sv
// Requester-side bus of the smolALU arbiter. Handshakes: a transfer happens on
// a clock edge where valid and ready are both 1; valid never waits for ready.
interface smol_alu_arb_if #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = smol_pkg::DATA_W,
   parameter int OP_W    = smol_pkg::OP_W
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*DATA_W-1:0] req_rs1;
   logic [NUM_REQ*DATA_W-1:0] req_rs2_or_imm;
   logic [NUM_REQ*OP_W-1:0]   req_op_sel;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [NUM_REQ-1:0]        rsp_ready;
   logic [DATA_W-1:0]         rsp_data;
   logic [1:0]                rsp_flags;

   modport master (
      output req_valid, req_rs1, req_rs2_or_imm, req_op_sel, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_flags
   );

   modport slave (
      input  req_valid, req_rs1, req_rs2_or_imm, req_op_sel, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_flags
   );
endinterface

// File: rtl/smol_rr_arbiter.sv
// Round-robin one-hot arbiter: first requester at or after ptr, with wrap.
// No grant at all while en is low.
module smol_rr_arbiter #(
   parameter int N     = 2,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   input  logic             en,
   output logic [N-1:0]     gnt
);
   logic [PTR_W-1:0] idx;
   logic             found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = PTR_W'((int'(ptr) + k) % N);
         if (en && !found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/smol_alu_arb.sv
// Shares one combinational smolALU between NUM_REQ requesters with a single
// registered response slot. Optional SMOL_ALU_ARB_STATS_EN adds grant/stall counters.
module smol_alu_arb
   import smol_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = smol_pkg::DATA_W,
   parameter int OP_W    = smol_pkg::OP_W
) (
   input  logic                clk,
   input  logic                rst,
   smol_alu_arb_if.slave       bus,
   output logic [DATA_W-1:0]   alu_rs1,
   output logic [DATA_W-1:0]   alu_rs2_or_imm,
   output logic [OP_W-1:0]     alu_op_sel,
   input  logic [DATA_W-1:0]   alu_out,
   input  logic                alu_carry,
   input  logic                alu_overflow,
   output arb_dbg_t            dbg_o
`ifdef SMOL_ALU_ARB_STATS_EN
  ,output logic [NUM_REQ*16-1:0] stat_grants
  ,output logic [15:0]           stat_stalls
`endif
);
   localparam int PTR_W = ptr_w(NUM_REQ);

   slot_state_e        state_q, state_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
   alu_flags_t         rsp_flags_q, rsp_flags_d;
   logic [PTR_W-1:0]   owner_q, owner_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]   gnt_idx;
   logic [NUM_REQ-1:0] gnt;
   logic               rsp_fire, can_issue, issue;

   // A draining slot can be refilled in the same cycle, giving one op per cycle.
   assign rsp_fire  = (state_q == SLOT_FULL) && bus.rsp_ready[owner_q];
   assign can_issue = !rst && ((state_q == SLOT_EMPTY) || rsp_fire);

   smol_rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_arb (
      .req (bus.req_valid),
      .ptr (rr_ptr_q),
      .en  (can_issue),
      .gnt (gnt)
   );

   assign issue         = |gnt;
   assign bus.req_ready = gnt;

   always_comb begin
      gnt_idx        = '0;
      alu_rs1        = '0;
      alu_rs2_or_imm = '0;
      alu_op_sel     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            gnt_idx        = PTR_W'(i);
            alu_rs1        = bus.req_rs1[i*DATA_W +: DATA_W];
            alu_rs2_or_imm = bus.req_rs2_or_imm[i*DATA_W +: DATA_W];
            alu_op_sel     = bus.req_op_sel[i*OP_W +: OP_W];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_flags_d = rsp_flags_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      if (issue) begin
         state_d     = SLOT_FULL;
         rsp_valid_d = gnt;
         rsp_data_d  = alu_out;
         rsp_flags_d = '{overflow: alu_overflow, carry: alu_carry};
         owner_d     = gnt_idx;
         rr_ptr_d    = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      end else if (rsp_fire) begin
         state_d     = SLOT_EMPTY;
         rsp_valid_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SLOT_EMPTY;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_flags_q <= '0;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_flags_q <= rsp_flags_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_flags = rsp_flags_q;
   assign dbg_o         = '{state: state_q, owner: 2'(owner_q), rr_ptr: 2'(rr_ptr_q)};

`ifdef SMOL_ALU_ARB_STATS_EN
   logic [NUM_REQ-1:0][15:0] grant_cnt_q;
   logic [15:0]              stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i] && grant_cnt_q[i] != 16'hFFFF) grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
         end
         if ((|bus.req_valid) && !issue && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stat_grants = grant_cnt_q;
   assign stat_stalls = stall_cnt_q;
`endif
endmodule
